// File: rtl/pc_target_table.sv
// Programmable branch-target table: DEPTH run-time writable jump targets with a
// registered lookup and a post-reset clearing sequencer. Optional macro: PCT_RELATIVE_EN.
module pc_target_table #(
   parameter int D = 10,
   parameter int A = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         lk_valid,
   output logic         lk_ready,
   input  logic [A-1:0] lk_idx,
   input  logic [D-1:0] lk_pc,
   output logic         tgt_valid,
   output logic [D-1:0] tgt,
   output logic         tgt_miss,
   input  logic         wr_en,
   input  logic [A-1:0] wr_idx,
   input  logic [D-1:0] wr_data,
   input  logic         wr_rel,
   output logic         init_busy
);

   localparam int DEPTH = 2**A;

   typedef enum logic {INIT, RUN} state_t;

   state_t         state, state_nxt;
   logic [A-1:0]   cnt, cnt_nxt;
   logic           clr_en;
   logic           wr_go;
   logic           lk_acc;

   logic [DEPTH-1:0] ent_vld;
   logic [D-1:0]     ent_data [DEPTH];

   logic           fwd;
   logic           e_vld;
   logic           e_rel;
   logic [D-1:0]   e_data;
   logic [D-1:0]   res_tgt;
   logic           res_miss;

   // Handshake: a lookup is taken on any rising edge where lk_valid && lk_ready;
   // its result appears as a single-cycle tgt_valid pulse right after that edge.
   assign lk_acc = lk_valid && lk_ready;
   assign wr_go  = wr_en && lk_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      lk_ready  = 1'b0;
      init_busy = 1'b0;
      clr_en    = 1'b0;
      case (state)
         INIT: begin
            init_busy = 1'b1;
            clr_en    = 1'b1;
            cnt_nxt   = cnt + 1'b1;
            if (cnt == {A{1'b1}}) state_nxt = RUN;
         end
         RUN: begin
            lk_ready = 1'b1;
         end
         default: begin
            state_nxt = INIT;
         end
      endcase
   end

   // Valid bits also clear asynchronously so nothing stale survives a reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_vld <= '0;
      end else if (clr_en) begin
         ent_vld[cnt] <= 1'b0;
      end else if (wr_go) begin
         ent_vld[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (clr_en) begin
         ent_data[cnt] <= '0;
      end else if (wr_go) begin
         ent_data[wr_idx] <= wr_data;
      end
   end

`ifdef PCT_RELATIVE_EN
   logic [DEPTH-1:0] ent_rel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_rel <= '0;
      end else if (clr_en) begin
         ent_rel[cnt] <= 1'b0;
      end else if (wr_go) begin
         ent_rel[wr_idx] <= wr_rel;
      end
   end
`else
   logic unused_wr_rel;
   assign unused_wr_rel = wr_rel;
`endif

   // Write-first: a same-cycle write to the looked-up index wins over storage.
   always_comb begin
      fwd      = wr_go && (wr_idx == lk_idx);
      e_vld    = fwd ? 1'b1 : ent_vld[lk_idx];
      e_data   = fwd ? wr_data : ent_data[lk_idx];
`ifdef PCT_RELATIVE_EN
      e_rel    = fwd ? wr_rel : ent_rel[lk_idx];
`else
      e_rel    = 1'b0;
`endif
      res_tgt  = e_data;
      res_miss = 1'b0;
      if (!e_vld) begin
         res_tgt  = lk_pc + D'(1);
         res_miss = 1'b1;
      end else if (e_rel) begin
         res_tgt  = lk_pc + e_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tgt_valid <= 1'b0;
         tgt       <= '0;
         tgt_miss  <= 1'b0;
      end else begin
         tgt_valid <= lk_acc;
         if (lk_acc) begin
            tgt      <= res_tgt;
            tgt_miss <= res_miss;
         end
      end
   end

endmodule

// File: tb/tb_pc_target_table.sv
// Bench for pc_target_table: directed vectors, literal checks and a table model
// scored every cycle. Honours PCT_RELATIVE_EN the same way the design does.
module tb_pc_target_table;

   localparam int D = 10;
   localparam int A = 4;
   localparam int DEPTH = 16;

`ifdef PCT_RELATIVE_EN
   localparam logic [D-1:0] EXP_REL5 = 10'd3;
   localparam logic [D-1:0] EXP_REL6 = 10'd16;
`else
   localparam logic [D-1:0] EXP_REL5 = 10'h3FF;
   localparam logic [D-1:0] EXP_REL6 = 10'd20;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         lk_valid;
   logic         lk_ready;
   logic [A-1:0] lk_idx;
   logic [D-1:0] lk_pc;
   logic         tgt_valid;
   logic [D-1:0] tgt;
   logic         tgt_miss;
   logic         wr_en;
   logic [A-1:0] wr_idx;
   logic [D-1:0] wr_data;
   logic         wr_rel;
   logic         init_busy;

   int total = 0;
   int bad   = 0;

   pc_target_table #(.D(D), .A(A)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .lk_valid  (lk_valid),
      .lk_ready  (lk_ready),
      .lk_idx    (lk_idx),
      .lk_pc     (lk_pc),
      .tgt_valid (tgt_valid),
      .tgt       (tgt),
      .tgt_miss  (tgt_miss),
      .wr_en     (wr_en),
      .wr_idx    (wr_idx),
      .wr_data   (wr_data),
      .wr_rel    (wr_rel),
      .init_busy (init_busy)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   // model: programmed entries, cycles since reset release, expected results
   logic [D:0]   exp_q[$];
   logic         m_vld  [DEPTH];
   logic         m_rel  [DEPTH];
   logic [D-1:0] m_data [DEPTH];
   int           m_cycles;
   logic         m_exp_valid;

   always @(posedge clk or negedge rst_n) begin
      logic [D-1:0] sum;
      if (!rst_n) begin
         m_cycles    = 0;
         m_exp_valid = 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            m_vld[i]  = 1'b0;
            m_rel[i]  = 1'b0;
            m_data[i] = '0;
         end
      end else begin
         m_exp_valid = 1'b0;
         if (m_cycles >= DEPTH) begin
            if (wr_en) begin
               m_vld[wr_idx]  = 1'b1;
               m_data[wr_idx] = wr_data;
`ifdef PCT_RELATIVE_EN
               m_rel[wr_idx]  = wr_rel;
`else
               m_rel[wr_idx]  = 1'b0;
`endif
            end
            if (lk_valid) begin
               if (!m_vld[lk_idx]) begin
                  sum = lk_pc + 10'd1;
                  exp_q.push_back({1'b1, sum});
               end else if (m_rel[lk_idx]) begin
                  sum = lk_pc + m_data[lk_idx];
                  exp_q.push_back({1'b0, sum});
               end else begin
                  exp_q.push_back({1'b0, m_data[lk_idx]});
               end
               m_exp_valid = 1'b1;
            end
         end
         if (m_cycles < 100000) m_cycles++;
      end
   end

   // scoreboard: every negedge
   logic [D-1:0] hold_tgt;
   logic         hold_miss;

   always @(negedge clk) begin
      logic [D:0] e;
      if (!rst_n) begin
         exp_q.delete();
         hold_tgt  = '0;
         hold_miss = 1'b0;
         chk("sb_rst_valid", tgt_valid, 0);
         chk("sb_rst_tgt", tgt, 0);
         chk("sb_rst_miss", tgt_miss, 0);
         chk("sb_rst_ready", lk_ready, 0);
         chk("sb_rst_busy", init_busy, 1);
      end else begin
         chk("sb_ready", lk_ready, (m_cycles >= DEPTH) ? 1 : 0);
         chk("sb_busy", init_busy, (m_cycles >= DEPTH) ? 0 : 1);
         chk("sb_valid", tgt_valid, m_exp_valid);
         if (m_exp_valid) begin
            if (exp_q.size() == 0) begin
               chk("sb_queue_empty", 0, 1);
            end else begin
               e = exp_q.pop_front();
               hold_tgt  = e[D-1:0];
               hold_miss = e[D];
            end
         end
         chk("sb_tgt", tgt, hold_tgt);
         chk("sb_miss", tgt_miss, hold_miss);
      end
   end

   // driver tasks
   task automatic do_write(input logic [A-1:0] idx, input logic [D-1:0] data, input logic rel);
      @(negedge clk);
      wr_en = 1'b1; wr_idx = idx; wr_data = data; wr_rel = rel;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic do_lookup(input logic [A-1:0] idx, input logic [D-1:0] pc,
                            input logic w, input logic [D-1:0] wdata,
                            input logic [D-1:0] exp_t, input logic exp_m, input string name);
      @(negedge clk);
      lk_valid = 1'b1; lk_idx = idx; lk_pc = pc;
      wr_en = w; wr_idx = idx; wr_data = wdata; wr_rel = 1'b0;
      @(negedge clk);
      lk_valid = 1'b0; wr_en = 1'b0;
      chk({name, "_valid"}, tgt_valid, 1);
      chk({name, "_tgt"}, tgt, exp_t);
      chk({name, "_miss"}, tgt_miss, exp_m);
      @(negedge clk);
      chk({name, "_pulse"}, tgt_valid, 0);
      chk({name, "_hold"}, tgt, exp_t);
   endtask

   task automatic wait_init(input string name);
      for (int i = 1; i <= DEPTH; i++) begin
         @(negedge clk);
         chk({name, "_busy"}, init_busy, (i < DEPTH) ? 1 : 0);
         chk({name, "_ready"}, lk_ready, (i < DEPTH) ? 0 : 1);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      lk_valid = 1'b0; lk_idx = '0; lk_pc = '0;
      wr_en = 1'b0; wr_idx = '0; wr_data = '0; wr_rel = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", tgt_valid, 0);
      chk("rst_busy", init_busy, 1);
      chk("rst_ready", lk_ready, 0);
      #1 rst_n = 1'b1;

      // INIT window: write and lookup attempts must have no effect
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         chk("init_busy", init_busy, 1);
         chk("init_ready", lk_ready, 0);
         if (i == 4) begin wr_en = 1'b1; wr_idx = 4'd1; wr_data = 10'd76; end
         if (i == 6) wr_en = 1'b0;
         if (i == 8) begin lk_valid = 1'b1; lk_idx = 4'd3; lk_pc = 10'd5; end
         if (i == 9) lk_valid = 1'b0;
      end
      lk_valid = 1'b1; lk_idx = 4'd9; lk_pc = 10'd100;
      @(negedge clk);
      chk("first_ready", lk_ready, 1);
      chk("first_busy", init_busy, 0);
      chk("first_not_taken", tgt_valid, 0);
      @(negedge clk);
      lk_valid = 1'b0;
      chk("first_valid", tgt_valid, 1);
      chk("first_tgt", tgt, 101);
      chk("first_miss", tgt_miss, 1);

      do_lookup(4'd1, 10'd50, 1'b0, '0, 10'd51, 1'b1, "init_wr_dropped");
      do_write(4'd2, 10'd45, 1'b0);
      do_lookup(4'd2, 10'd7, 1'b0, '0, 10'd45, 1'b0, "abs");
      do_lookup(4'd3, 10'd0, 1'b1, 10'd103, 10'd103, 1'b0, "fwd");
      do_write(4'd5, 10'h3FF, 1'b1);
      do_lookup(4'd5, 10'd4, 1'b0, '0, EXP_REL5, 1'b0, "rel_neg");
      do_write(4'd6, 10'd20, 1'b1);
      do_lookup(4'd6, 10'd1020, 1'b0, '0, EXP_REL6, 1'b0, "rel_wrap");

      // write and lookup on different indices in one cycle
      @(negedge clk);
      wr_en = 1'b1; wr_idx = 4'd7; wr_data = 10'd200; wr_rel = 1'b0;
      lk_valid = 1'b1; lk_idx = 4'd8; lk_pc = 10'd300;
      @(negedge clk);
      wr_en = 1'b0; lk_valid = 1'b0;
      chk("indep_tgt", tgt, 301);
      chk("indep_miss", tgt_miss, 1);
      do_lookup(4'd7, 10'd0, 1'b0, '0, 10'd200, 1'b0, "indep_stored");

      // back-to-back lookups, scored by the model
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         lk_valid = 1'b1;
         lk_idx = A'($urandom_range(0, 9));
         lk_pc = D'(500 + 37 * i);
      end
      @(negedge clk);
      lk_valid = 1'b0;
      repeat (2) @(negedge clk);

      // reset with a lookup in flight
      @(negedge clk);
      lk_valid = 1'b1; lk_idx = 4'd2; lk_pc = 10'd7;
      @(posedge clk);
      #1 rst_n = 1'b0;
      lk_valid = 1'b0;
      #1;
      chk("mid_rst_valid", tgt_valid, 0);
      chk("mid_rst_busy", init_busy, 1);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;

      // reset again part way through INIT
      repeat (6) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      wait_init("reinit");
      do_lookup(4'd2, 10'd7, 1'b0, '0, 10'd8, 1'b1, "stale_after_rst");

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_target_table.md
# pc_target_table

Programmable branch-target table for the fetch stage: a DEPTH-entry, D-bit store of jump targets indexed by the branch instruction's LUT field. It replaces fixed-content lookup with run-time writable entries, per-entry absolute/PC-relative mode, a registered lookup with valid/ready handshake, and a post-reset clearing sequencer. It sits between the decoder's index field and the PC next-value mux.

## Interface
- D, 10: target / PC width in bits
- A, 4: index width; DEPTH = 2**A entries (derived, not overridable)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- lk_valid  in  1  lookup request
- lk_ready  out  1  table accepts lookups (0 during INIT)
- lk_idx  in  A  entry to look up
- lk_pc  in  D  current PC, used for relative entries and misses
- tgt_valid  out  1  tgt/tgt_miss valid this cycle (one-cycle pulse per accepted lookup)
- tgt  out  D  resolved target
- tgt_miss  out  1  looked-up entry was unprogrammed
- wr_en  in  1  write strobe
- wr_idx  in  A  entry to write
- wr_data  in  D  target (absolute) or two's-complement offset (relative)
- wr_rel  in  1  entry is PC-relative (see Configuration)
- init_busy  out  1  clearing sequencer active

## Operation
- Each entry holds {vld, rel, data[D-1:0]}.
- FSM states: INIT, RUN. Reset enters INIT with counter = 0.
- INIT: one entry per cycle gets vld=0, rel=0, data=0; counter increments; after writing entry DEPTH-1, go to RUN. init_busy=1, lk_ready=0 throughout INIT. wr_en in INIT is dropped (no effect, no later replay). lk_valid in INIT is not accepted.
- RUN: lk_ready=1; init_busy=0. No return to INIT except via rst_n.
- Write (RUN, wr_en=1): entry[wr_idx] <= {1, wr_rel, wr_data} at the clock edge.
- Lookup accepted when lk_valid && lk_ready. Resolution of entry e at index lk_idx:
  - e.vld=0: tgt = (lk_pc + 1) mod 2**D, tgt_miss = 1.
  - e.vld=1, e.rel=0: tgt = e.data, tgt_miss = 0.
  - e.vld=1, e.rel=1: tgt = (lk_pc + e.data) mod 2**D, e.data signed; carry out discarded.
- Same-cycle write and lookup to the same index: lookup uses the newly written {1, wr_rel, wr_data} (write-first forwarding). Different indices: independent.
- tgt and tgt_miss hold their last values when tgt_valid=0.

## Timing
- Reset values (asynchronous, while rst_n=0): tgt_valid=0, tgt=0, tgt_miss=0, lk_ready=0, init_busy=1.
- After rst_n release: INIT takes exactly DEPTH cycles; lk_ready rises at edge DEPTH (first acceptable lookup in cycle DEPTH+1 counting the first post-reset edge as 1).
- Lookup latency: 1 cycle. Request accepted at edge N -> tgt_valid=1 with result after edge N, for one cycle. Back-to-back lookups give a tgt_valid every cycle.
- Write visible to lookups: same cycle via forwarding, and from storage thereafter.
- rst_n asserted mid-INIT or mid-RUN: all entries are considered stale, any in-flight result is discarded (tgt_valid=0), INIT restarts from entry 0.

## Configuration
- PCT_RELATIVE_EN defined: rel bit stored per entry, relative resolution as above.
- Not defined: rel bit not implemented, wr_rel ignored, every valid entry is absolute (tgt = e.data). Port list unchanged.

## Test plan
- Reset, D=10, A=4: init_busy=1 and lk_ready=0 for 16 cycles after release; lk_ready=1 on cycle 17; lookup any index with lk_pc=100 -> tgt=101, tgt_miss=1.
- Write idx 2 = 45 absolute, then lookup idx 2 with lk_pc=7 -> next cycle tgt=45, tgt_miss=0, tgt_valid one-cycle pulse.
- (PCT_RELATIVE_EN) write idx 5 = 10'h3FF rel; lookup lk_pc=4 -> tgt=3; write idx 6 = 20 rel, lookup lk_pc=1020 -> tgt=16 (wrap).
- Same-cycle write idx 3 = 103 and lookup idx 3 -> tgt=103, tgt_miss=0; wr_en during INIT to idx 1 = 76, then lookup idx 1 after INIT -> tgt_miss=1.
- Without PCT_RELATIVE_EN: write idx 5 = 10'h3FF with wr_rel=1, lookup lk_pc=4 -> tgt=10'h3FF.
- Assert rst_n=0 during a lookup in flight after programming idx 2: tgt_valid stays 0, init_busy=1; after re-INIT lookup idx 2 -> tgt_miss=1.
